// File: rtl/mic_tdm_scheduler_pkg.sv
// mic_tdm_pkg: shared types and constants for the microphone TDM scheduler.
//   NIB_W                - width of one link nibble
//   state_t              - scheduler FSM states
//   nibbles_per_sample() - number of link slots one sample occupies
package mic_tdm_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    function automatic int unsigned nibbles_per_sample(input int unsigned sample_w);
        return sample_w / NIB_W;
    endfunction

endpackage

// File: rtl/mic_tdm_scheduler_if.sv
// mic_tdm_scheduler_if: bundle of the sample inputs, slot tick, link outputs
// and overrun status/clear of the microphone TDM scheduler.
//   master modport - sample source / link consumer side
//   slave  modport - the scheduler itself
// Optional MIC_TDM_SCHED_PARITY_EN adds out_parity (even parity over
// {out_sof, out_ch, out_nibble}).
interface mic_tdm_scheduler_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SAMPLE_W = 16
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]               in_valid;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] in_data;
    logic                            slot_en;
    logic                            out_valid;
    logic [3:0]                      out_nibble;
    logic [CH_W-1:0]                 out_ch;
    logic                            out_sof;
    logic [NUM_CH-1:0]               overrun;
    logic [NUM_CH-1:0]               overrun_clr;
`ifdef MIC_TDM_SCHED_PARITY_EN
    logic                            out_parity;
`endif

    modport master (
        output in_valid, in_data, slot_en, overrun_clr,
`ifdef MIC_TDM_SCHED_PARITY_EN
        input  out_parity,
`endif
        input  out_valid, out_nibble, out_ch, out_sof, overrun
    );

    modport slave (
        input  in_valid, in_data, slot_en, overrun_clr,
`ifdef MIC_TDM_SCHED_PARITY_EN
        output out_parity,
`endif
        output out_valid, out_nibble, out_ch, out_sof, overrun
    );

endinterface

// File: rtl/mic_tdm_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among NUM_CH requests.
//   req         - request vector
//   last_grant  - most recently granted index; search starts one above it
//   grant_valid - at least one request present
//   grant_idx   - winning index (0 when grant_valid is low)
module rr_arbiter #(
    parameter  int unsigned NUM_CH = 2,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_idx
);
    int unsigned idx;

    // Offset 1..NUM_CH so the last granted channel is checked last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mic_tdm_scheduler.sv
// mic_tdm_scheduler: shares one nibble-wide TDM link between NUM_CH mic
// channels. Each channel has a one-deep holding register; pending channels
// are granted round-robin and streamed MSB nibble first, one nibble per
// slot_en, tagged with channel ID and start-of-frame.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - mic_tdm_scheduler_if.slave (samples, slot tick, link, overrun)
// Optional MIC_TDM_SCHED_PARITY_EN adds registered bus.out_parity.
module mic_tdm_scheduler
    import mic_tdm_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SAMPLE_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    mic_tdm_scheduler_if.slave bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned NIBS  = nibbles_per_sample(SAMPLE_W);
    localparam int unsigned CNT_W = $clog2(NIBS + 1);

    state_t                          state;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] hold;
    logic [NUM_CH-1:0]               pending;
    logic [NUM_CH-1:0]               overrun;
    logic [NUM_CH-1:0]               grant_now;
    logic [SAMPLE_W-1:0]             shreg;
    logic [CNT_W-1:0]                nib_cnt;
    logic [CH_W-1:0]                 last_grant;
    logic [CH_W-1:0]                 grant_idx;
    logic                            grant_valid;
    logic                            grant_fire;
    logic                            valid;
    logic                            sof;
    logic [CH_W-1:0]                 ch;
    logic [NIB_W-1:0]                nibble;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req         (pending),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign grant_fire = (state == IDLE) && bus.slot_en && grant_valid;
    assign grant_now  = grant_fire ? (NUM_CH'(1) << grant_idx) : '0;

    // A grant consumes the registered pending bit; a same-cycle capture
    // re-arms it, so only a capture onto an ungranted pending sample overruns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= bus.in_valid | (pending & ~grant_now);
            overrun <= (bus.in_valid & pending & ~grant_now) | (overrun & ~bus.overrun_clr);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (bus.in_valid[i]) begin
                    hold[i] <= bus.in_data[i];
                end
            end
        end
    end

`ifdef MIC_TDM_SCHED_PARITY_EN
    logic parity;
    assign bus.out_parity = parity;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            nib_cnt    <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            shreg      <= '0;
            valid      <= 1'b0;
            nibble     <= '0;
            ch         <= '0;
            sof        <= 1'b0;
`ifdef MIC_TDM_SCHED_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_fire) begin
                        shreg      <= hold[grant_idx] << NIB_W;
                        last_grant <= grant_idx;
                        nibble     <= hold[grant_idx][SAMPLE_W-1 -: NIB_W];
                        ch         <= grant_idx;
                        sof        <= 1'b1;
                        valid      <= 1'b1;
`ifdef MIC_TDM_SCHED_PARITY_EN
                        parity     <= ^{1'b1, grant_idx, hold[grant_idx][SAMPLE_W-1 -: NIB_W]};
`endif
                        if (NIBS > 1) begin
                            nib_cnt <= CNT_W'(1);
                            state   <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.slot_en) begin
                        nibble <= shreg[SAMPLE_W-1 -: NIB_W];
                        shreg  <= shreg << NIB_W;
                        sof    <= 1'b0;
                        valid  <= 1'b1;
`ifdef MIC_TDM_SCHED_PARITY_EN
                        parity <= ^{1'b0, ch, shreg[SAMPLE_W-1 -: NIB_W]};
`endif
                        if (nib_cnt == CNT_W'(NIBS - 1)) begin
                            nib_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            nib_cnt <= nib_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = valid;
    assign bus.out_nibble = nibble;
    assign bus.out_ch     = ch;
    assign bus.out_sof    = sof;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_mic_tdm_scheduler.sv
// tb_mic_tdm_scheduler: scoreboard bench for mic_tdm_scheduler (NUM_CH=2,
// SAMPLE_W=16). Expected nibbles are queued when samples are driven and
// compared as out_valid pulses appear. Covers out_parity when
// MIC_TDM_SCHED_PARITY_EN is defined.
module tb_mic_tdm_scheduler;
    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CH_W     = 1;

    typedef struct packed {
        logic [3:0]      nib;
        logic [CH_W-1:0] ch;
        logic            sof;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   seen  = 0;
    int   cyc   = 0;
    int   slot_mode = 0;
    exp_t sb[$];
    logic [3:0]      last_nib = '0;
    logic [CH_W-1:0] last_ch  = '0;
    logic            last_sof = 1'b0;

    mic_tdm_scheduler_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();

    mic_tdm_scheduler #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // slot_mode: 0 = no slots, 1 = every cycle, 4 = every 4th cycle
    initial begin
        bus.slot_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.slot_en = (slot_mode == 1) || (slot_mode == 4 && (cyc % 4) == 0);
        end
    end

    // Monitor: pop on every out_valid, otherwise outputs must hold the
    // last expected nibble/channel/sof.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            last_nib = '0;
            last_ch  = '0;
            last_sof = 1'b0;
        end else if (bus.out_valid) begin
            seen++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(bus.out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("nibble", 32'(bus.out_nibble), 32'(e.nib));
                check("ch", 32'(bus.out_ch), 32'(e.ch));
                check("sof", 32'(bus.out_sof), 32'(e.sof));
`ifdef MIC_TDM_SCHED_PARITY_EN
                check("parity", 32'(bus.out_parity), 32'(^{e.sof, e.ch, e.nib}));
`endif
                last_nib = e.nib;
                last_ch  = e.ch;
                last_sof = e.sof;
            end
        end else begin
            check("hold", 32'({bus.out_sof, bus.out_ch, bus.out_nibble}),
                  32'({last_sof, last_ch, last_nib}));
        end
    end

    task automatic push_sample(input logic [CH_W-1:0] ch, input logic [15:0] data);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.nib = data[15-4*i -: 4];
            e.ch  = ch;
            e.sof = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [1:0] clr);
        @(posedge clk);
        #1;
        bus.in_valid    = v;
        bus.in_data[0]  = d0;
        bus.in_data[1]  = d1;
        bus.overrun_clr = clr;
    endtask

    task automatic quiet();
        @(posedge clk);
        #1;
        bus.in_valid    = '0;
        bus.overrun_clr = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'(0));
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int cnt;
        int consec;
        logic prev;
        int base;

        bus.in_valid    = '0;
        bus.in_data     = '0;
        bus.overrun_clr = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'(0));
        check("rst_outs", 32'({bus.out_sof, bus.out_ch, bus.out_nibble}), 32'(0));
        check("rst_overrun", 32'(bus.overrun), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slot_mode = 1;

        // Both channels at once: ch0 first after reset, no gap between samples
        drive(2'b11, 16'h1234, 16'hABCD, 2'b00);
        push_sample(1'b0, 16'h1234);
        push_sample(1'b1, 16'hABCD);
        quiet();
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("first_valid", 32'(bus.out_valid), 32'(1));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            check("b2b_valid", 32'(bus.out_valid), 32'(1));
        end
        @(negedge clk);
        #1;
        check("gap_after_pair", 32'(bus.out_valid), 32'(0));
        wait_drain(40);

        // Single sample on ch0
        drive(2'b01, 16'hA5C3, 16'h0000, 2'b00);
        push_sample(1'b0, 16'hA5C3);
        quiet();
        wait_drain(40);

        // last_grant is now ch0, so ch1 wins the next pair
        drive(2'b11, 16'h5678, 16'hEF01, 2'b00);
        push_sample(1'b1, 16'hEF01);
        push_sample(1'b0, 16'h5678);
        quiet();
        wait_drain(40);

        // Overrun on ch1 while ch0 streams
        check("ovr_pre", 32'(bus.overrun), 32'(0));
        drive(2'b01, 16'h3C3C, 16'h0000, 2'b00);
        push_sample(1'b0, 16'h3C3C);
        drive(2'b10, 16'h0000, 16'h1111, 2'b00);
        drive(2'b10, 16'h0000, 16'h2222, 2'b00);
        push_sample(1'b1, 16'h2222);
        quiet();
        wait_drain(40);
        check("ovr_set", 32'(bus.overrun), 32'(2'b10));
        drive(2'b00, 16'h0000, 16'h0000, 2'b10);
        quiet();
        @(negedge clk);
        #1;
        check("ovr_clr", 32'(bus.overrun), 32'(0));

        // Set and clear in the same cycle: set wins
        slot_mode = 0;
        repeat (2) @(posedge clk);
        drive(2'b10, 16'h0000, 16'h4444, 2'b00);
        drive(2'b10, 16'h0000, 16'h5555, 2'b10);
        quiet();
        @(negedge clk);
        #1;
        check("ovr_set_wins", 32'(bus.overrun), 32'(2'b10));
        push_sample(1'b1, 16'h5555);
        slot_mode = 1;
        wait_drain(40);
        drive(2'b00, 16'h0000, 16'h0000, 2'b10);
        quiet();
        @(negedge clk);
        #1;
        check("ovr_clr2", 32'(bus.overrun), 32'(0));

        // Sparse slots: one nibble per slot, never two valids in a row
        slot_mode = 4;
        drive(2'b01, 16'hBEEF, 16'h0000, 2'b00);
        push_sample(1'b0, 16'hBEEF);
        quiet();
        cnt = 0;
        consec = 0;
        prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) cnt++;
            if (bus.out_valid && prev) consec++;
            prev = bus.out_valid;
        end
        check("sparse_count", 32'(cnt), 32'(4));
        check("sparse_b2b", 32'(consec), 32'(0));
        wait_drain(40);

        // Reset mid-frame after the 2nd nibble of CAFE
        slot_mode = 1;
        base = seen;
        drive(2'b01, 16'hCAFE, 16'h0000, 2'b00);
        push_sample(1'b0, 16'hCAFE);
        void'(sb.pop_back());
        void'(sb.pop_back());
        quiet();
        n = 0;
        while (seen < base + 2 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("two_nibbles_seen", 32'(seen - base), 32'(2));
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'(0));
        check("arst_outs", 32'({bus.out_sof, bus.out_ch, bus.out_nibble}), 32'(0));
        check("arst_overrun", 32'(bus.overrun), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
        check("post_rst_valid", 32'(cnt), 32'(0));
        check("post_rst_sb", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
